// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the Mini SRC datapath.
// Sequences fetch (T0-T2), decodes the IR opcode and drives the per-step
// control word for execute steps T3-T7. Memory steps are stretched by
// MEM_WAIT cycles. Also handles run/stop handshaking and illegal-opcode traps.
module control_sequencer #(
    parameter int OPC_LSB  = 27,
    parameter int MEM_WAIT = 1,
    parameter int WAIT_W   = 3
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run_req,
    input  logic        stop_req,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic [41:0] ctrl,
    output logic [2:0]  tstep,
    output logic        halted,
    output logic        illegal
);
    typedef logic [41:0] cw_t;

    // Control word bit masks, LSB first
    localparam cw_t PCOUT     = cw_t'(1) << 0;
    localparam cw_t PCIN      = cw_t'(1) << 1;
    localparam cw_t INCPC     = cw_t'(1) << 2;
    localparam cw_t MARIN     = cw_t'(1) << 3;
    localparam cw_t MDRIN     = cw_t'(1) << 4;
    localparam cw_t MDROUT    = cw_t'(1) << 5;
    localparam cw_t MDMUXREAD = cw_t'(1) << 6;
    localparam cw_t RAMREAD   = cw_t'(1) << 7;
    localparam cw_t RAMWRITE  = cw_t'(1) << 8;
    localparam cw_t IRIN      = cw_t'(1) << 9;
    localparam cw_t YIN       = cw_t'(1) << 10;
    localparam cw_t ZLOWIN    = cw_t'(1) << 11;
    localparam cw_t ZHIGHIN   = cw_t'(1) << 12;
    localparam cw_t ZLOWOUT   = cw_t'(1) << 13;
    localparam cw_t ZHIGHOUT  = cw_t'(1) << 14;
    localparam cw_t HIIN      = cw_t'(1) << 15;
    localparam cw_t LOIN      = cw_t'(1) << 16;
    localparam cw_t HIOUT     = cw_t'(1) << 17;
    localparam cw_t LOOUT     = cw_t'(1) << 18;
    localparam cw_t CSEOUT    = cw_t'(1) << 19;
    localparam cw_t INPORTOUT = cw_t'(1) << 20;
    localparam cw_t OUTPORTIN = cw_t'(1) << 21;
    localparam cw_t GRA       = cw_t'(1) << 22;
    localparam cw_t GRB       = cw_t'(1) << 23;
    localparam cw_t GRC       = cw_t'(1) << 24;
    localparam cw_t RIN       = cw_t'(1) << 25;
    localparam cw_t ROUT      = cw_t'(1) << 26;
    localparam cw_t BAOUT     = cw_t'(1) << 27;
    localparam cw_t CONIN     = cw_t'(1) << 28;
    localparam cw_t ALU_ADD   = cw_t'(1) << 29;
    localparam cw_t ALU_SUB   = cw_t'(1) << 30;
    localparam cw_t ALU_MUL   = cw_t'(1) << 31;
    localparam cw_t ALU_DIV   = cw_t'(1) << 32;
    localparam cw_t ALU_AND   = cw_t'(1) << 33;
    localparam cw_t ALU_OR    = cw_t'(1) << 34;
    localparam cw_t ALU_SHR   = cw_t'(1) << 35;
    localparam cw_t ALU_SHRA  = cw_t'(1) << 36;
    localparam cw_t ALU_SHL   = cw_t'(1) << 37;
    localparam cw_t ALU_ROR   = cw_t'(1) << 38;
    localparam cw_t ALU_ROL   = cw_t'(1) << 39;
    localparam cw_t ALU_NEG   = cw_t'(1) << 40;
    localparam cw_t ALU_NOT   = cw_t'(1) << 41;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    typedef enum logic {HALTED = 1'b0, RUN = 1'b1} mode_e;

    mode_e             mode_q;
    logic [2:0]        step_q;
    logic [WAIT_W-1:0] wait_q;

    logic [4:0] opc;
    logic       run;
    logic       mem_step;
    logic [2:0] last_step;
    logic       force_halt;
    cw_t        alu_w;
    logic       unused_ir;

    assign opc    = ir[OPC_LSB+4:OPC_LSB];
    assign run    = (mode_q == RUN);
    assign tstep  = step_q;
    assign halted = (mode_q == HALTED);
    // Only the opcode field is decoded here; the rest of IR belongs to the datapath
    assign unused_ir = ^ir;

    // Instruction length, memory-step detection and ALU op select from the opcode
    always_comb begin
        mem_step   = run && ((step_q == 3'd1) ||
                             (step_q == 3'd6 && opc == OP_LD) ||
                             (step_q == 3'd7 && opc == OP_ST));
        force_halt = (opc == OP_HALT) || (opc[4:2] == 3'b111);
        last_step  = 3'd3;
        alu_w      = '0;
        case (opc) inside
            5'd0, 5'd2:                 last_step = 3'd7;
            5'd1, [5'd3:5'd14]:         last_step = 3'd5;
            5'd15, 5'd16, 5'd19:        last_step = 3'd6;
            5'd17, 5'd18, 5'd21:        last_step = 3'd4;
            5'd26, 5'd27:               last_step = 3'd2;
            default:                    last_step = 3'd3;
        endcase
        case (opc)
            5'd1, 5'd3, 5'd12: alu_w = ALU_ADD;
            5'd4:              alu_w = ALU_SUB;
            5'd5, 5'd13:       alu_w = ALU_AND;
            5'd6, 5'd14:       alu_w = ALU_OR;
            5'd7:              alu_w = ALU_SHR;
            5'd8:              alu_w = ALU_SHRA;
            5'd9:              alu_w = ALU_SHL;
            5'd10:             alu_w = ALU_ROR;
            5'd11:             alu_w = ALU_ROL;
            5'd15:             alu_w = ALU_MUL;
            5'd16:             alu_w = ALU_DIV;
            5'd17:             alu_w = ALU_NEG;
            5'd18:             alu_w = ALU_NOT;
            default:           alu_w = '0;
        endcase
    end

    // The trap is flagged during T3 only; the sequencer halts right after
    assign illegal = run && (step_q == 3'd3) && (opc[4:2] == 3'b111);

    // Mode / step / wait-state sequencer
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mode_q <= HALTED;
            step_q <= '0;
            wait_q <= '0;
        end else begin
            case (mode_q)
                HALTED: begin
                    step_q <= '0;
                    wait_q <= '0;
                    if (run_req) mode_q <= RUN;
                end
                RUN: begin
                    if (mem_step && wait_q != WAIT_LAST) begin
                        wait_q <= wait_q + 1'b1;
                    end else begin
                        wait_q <= '0;
                        if (step_q == last_step) begin
                            step_q <= '0;
                            if (stop_req || force_halt) mode_q <= HALTED;
                        end else begin
                            step_q <= step_q + 3'd1;
                        end
                    end
                end
                default: mode_q <= HALTED;
            endcase
        end
    end

    // Control word decode from the registered step and the IR opcode
    always_comb begin
        ctrl = '0;
        if (run) begin
            case (step_q)
                3'd0: ctrl = PCOUT | MARIN | INCPC | ZLOWIN;
                // PCin only on the first T1 cycle so the PC is loaded once
                3'd1: ctrl = ZLOWOUT | MDMUXREAD | RAMREAD | MDRIN |
                             ((wait_q == '0) ? PCIN : '0);
                3'd2: ctrl = MDROUT | IRIN;
                default: begin
                    case (opc) inside
                        [5'd3:5'd11]: case (step_q)
                            3'd3: ctrl = GRB | ROUT | YIN;
                            3'd4: ctrl = GRC | ROUT | alu_w | ZLOWIN;
                            3'd5: ctrl = ZLOWOUT | GRA | RIN;
                            default: ctrl = '0;
                        endcase
                        OP_LDI, [5'd12:5'd14]: case (step_q)
                            3'd3: ctrl = GRB | YIN | ((opc == OP_LDI) ? BAOUT : ROUT);
                            3'd4: ctrl = CSEOUT | alu_w | ZLOWIN;
                            3'd5: ctrl = ZLOWOUT | GRA | RIN;
                            default: ctrl = '0;
                        endcase
                        OP_LD, OP_ST: case (step_q)
                            3'd3: ctrl = GRB | BAOUT | YIN;
                            3'd4: ctrl = CSEOUT | ALU_ADD | ZLOWIN;
                            3'd5: ctrl = ZLOWOUT | MARIN;
                            3'd6: ctrl = (opc == OP_LD) ? (MDMUXREAD | RAMREAD | MDRIN)
                                                        : (GRA | ROUT | MDRIN);
                            3'd7: ctrl = (opc == OP_LD) ? (MDROUT | GRA | RIN) : RAMWRITE;
                            default: ctrl = '0;
                        endcase
                        5'd15, 5'd16: case (step_q)
                            3'd3: ctrl = GRA | ROUT | YIN;
                            3'd4: ctrl = GRB | ROUT | alu_w | ZLOWIN | ZHIGHIN;
                            3'd5: ctrl = ZLOWOUT | LOIN;
                            3'd6: ctrl = ZHIGHOUT | HIIN;
                            default: ctrl = '0;
                        endcase
                        5'd17, 5'd18: case (step_q)
                            3'd3: ctrl = GRB | ROUT | alu_w | ZLOWIN;
                            3'd4: ctrl = ZLOWOUT | GRA | RIN;
                            default: ctrl = '0;
                        endcase
                        OP_BRX: case (step_q)
                            3'd3: ctrl = GRA | ROUT | CONIN;
                            3'd4: ctrl = PCOUT | YIN;
                            3'd5: ctrl = CSEOUT | ALU_ADD | ZLOWIN;
                            3'd6: ctrl = ZLOWOUT | (con_ff ? PCIN : '0);
                            default: ctrl = '0;
                        endcase
                        5'd20: ctrl = GRA | ROUT | PCIN;
                        5'd21: ctrl = (step_q == 3'd3) ? (PCOUT | GRB | RIN)
                                                       : (GRA | ROUT | PCIN);
                        5'd22: ctrl = INPORTOUT | GRA | RIN;
                        5'd23: ctrl = GRA | ROUT | OUTPORTIN;
                        5'd24: ctrl = HIOUT | GRA | RIN;
                        5'd25: ctrl = LOOUT | GRA | RIN;
                        default: ctrl = '0;
                    endcase
                end
            endcase
        end
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Hardwired control unit for the Mini SRC datapath. It steps the fetch sequence T0–T2, then decodes the IR opcode and emits the per-step control word for the execute steps. It replaces bench-driven control with a self-sequencing FSM that adds memory wait states, run/stop handshaking and illegal-opcode trapping. It sits beside the Datapath and drives all of its control inputs.

Parameters:
OPC_LSB, 27, LSB of the 5-bit opcode field in ir (field is ir[OPC_LSB+4:OPC_LSB]).
MEM_WAIT, 1, extra cycles each memory step is held (0..7).
WAIT_W, 3, width of the wait counter (must satisfy 2**WAIT_W > MEM_WAIT).

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous reset, active-low.
run_req  in  1  start request; honoured only in HALTED.
stop_req  in  1  sampled on the last step of an instruction; if 1, go to HALTED instead of T0.
ir  in  32  datapath IR contents.
con_ff  in  1  branch condition flip-flop output.
ctrl  out  42  control word, LSB first: PCout PCin IncPC MARin MDRin MDRout MDMuxread RAMread RAMwrite IRin Yin Zlowin Zhighin Zlowout Zhighout HIin LOin HIout LOout CSEout InPortout OutPortin Gra Grb Grc Rin Rout BAout CONin ADD SUB MUL DIV AND OR SHR SHRA SHL ROR ROL NEG NOT.
tstep  out  3  current step number (T0=0 .. T7=7).
halted  out  1  1 while in HALTED.
illegal  out  1  one-cycle pulse on an illegal-opcode trap.

Behaviour:
- State is held in registers: mode {HALTED, RUN}, step 0..7, wait counter. ctrl is combinational from the registered state and ir. The opcode decode is valid from T3, because IR loads at the end of T2.
- Reset (clear=0, asynchronous): mode=HALTED, step=0, wait=0. ctrl=0, tstep=0, halted=1, illegal=0. Applying reset mid-instruction forces ctrl=0 immediately.
- HALTED: ctrl=0. If run_req=1 at a rising edge, enter RUN at T0. run_req is ignored while in RUN.
- Each step lasts 1 cycle. A memory step (any step asserting RAMread or RAMwrite) lasts MEM_WAIT+1 cycles: ctrl and tstep are held, and the wait counter counts 0..MEM_WAIT before the step advances.
- Fetch:
  T0: PCout MARin IncPC Zlowin.
  T1: Zlowout PCin MDMuxread RAMread MDRin (memory step). PCin asserts only on the first cycle of T1.
  T2: MDRout IRin.
- Opcode map and execute steps:
  - 00011–01011 (add sub and or shr shra shl ror rol):
    T3: Grb Rout Yin.
    T4: Grc Rout op Zlowin.
    T5: Zlowout Gra Rin.
  - 01100/01101/01110 (addi andi ori) and 00001 (ldi):
    T3: Grb Rout Yin. For ldi, BAout replaces Rout.
    T4: CSEout op Zlowin, where op=ADD for ldi and addi.
    T5: Zlowout Gra Rin.
  - 00000 (ld):
    T3: Grb BAout Yin.
    T4: CSEout ADD Zlowin.
    T5: Zlowout MARin.
    T6: MDMuxread RAMread MDRin (memory step).
    T7: MDRout Gra Rin.
  - 00010 (st):
    T3–T5: as ld.
    T6: Gra Rout MDRin (MDMuxread=0).
    T7: RAMwrite (memory step).
  - 01111/10000 (mul div):
    T3: Gra Rout Yin.
    T4: Grb Rout MUL|DIV Zlowin Zhighin.
    T5: Zlowout LOin.
    T6: Zhighout HIin.
  - 10001/10010 (neg not):
    T3: Grb Rout op Zlowin.
    T4: Zlowout Gra Rin.
  - 10011 (brx):
    T3: Gra Rout CONin.
    T4: PCout Yin.
    T5: CSEout ADD Zlowin.
    T6: Zlowout, plus PCin only if con_ff=1 during T6.
  - 10100 (jr): T3: Gra Rout PCin.
  - 10101 (jal):
    T3: PCout Grb Rin.
    T4: Gra Rout PCin.
  - 10110 (in): T3: InPortout Gra Rin.
  - 10111 (out): T3: Gra Rout OutPortin.
  - 11000 (mfhi): T3: HIout Gra Rin.
  - 11001 (mflo): T3: LOout Gra Rin.
  - 11010 (nop): ends after T2.
  - 11011 (halt): T2 is the last step; go to HALTED regardless of stop_req.
  - 11100–11111 (illegal): illegal=1 for one cycle at T3 with ctrl=0, then HALTED.
- End of instruction: after the last step, go to T0 if stop_req=0, else HALTED. If stop_req and run_req are both high on the last step, HALTED wins.
- Invariant: at most one bus driver among {PCout MDRout Zlowout Zhighout HIout LOout CSEout InPortout Rout BAout} is asserted per cycle.

Test Plan:
- Reset and run: release clear, hold run_req=0 for 5 cycles -> ctrl=0, halted=1. Pulse run_req -> next cycle tstep=0 with ctrl = PCout|MARin|IncPC|Zlowin.
- addi with MEM_WAIT=1: ir=32'h61A7FFFB (addi R3,R4,-5) -> T1 held 2 cycles. T3 asserts Grb Rout Yin, T4 CSEout ADD Zlowin, T5 Zlowout Gra Rin. Next cycle tstep=0.
- Load: ld (opcode 00000) -> 8 steps with 2 memory steps, 10 cycles total at MEM_WAIT=1. T6 asserts RAMread and MDMuxread.
- Branch taken/not taken: brx with con_ff=1 -> PCin high in T6. Repeat with con_ff=0 -> PCin low in T6, Zlowout still high.
- Halt and illegal: halt (11011) -> halted=1 the cycle after T2. Opcode 11110 -> illegal pulses exactly 1 cycle at T3, then halted=1. stop_req=1 on the T5 of add -> HALTED, not T0.
- Reset mid-operation: assert clear during T4 of mul -> ctrl=0 immediately. After release, state is HALTED.
